// File: rtl/pe_multibank.sv
// Weight-stationary systolic PE with NUM_BANKS explicitly addressed weight banks,
// rotating active-bank pointer and optional saturating accumulation.
module pe_multibank #(
  parameter int unsigned ROW_ID               = 0,
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int unsigned DATA_WIDTH_IN        = 8,
  parameter int unsigned DATA_WIDTH_ACCUM     = 32,
  parameter int unsigned NUM_BANKS            = 4,
  parameter int unsigned SATURATE             = 1,
  localparam int unsigned INDEX_WIDTH         = $clog2(SYSTOLIC_ARRAY_WIDTH),
  localparam int unsigned BANK_WIDTH          = $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pe_enabled,
  input  logic                        pe_valid_in,
  input  logic [DATA_WIDTH_IN-1:0]    pe_input_in,
  input  logic                        pe_switch_in,
  input  logic                        pe_accept_w_in,
  input  logic [DATA_WIDTH_IN-1:0]    pe_weight_in,
  input  logic [INDEX_WIDTH-1:0]      pe_index_in,
  input  logic [BANK_WIDTH-1:0]       pe_bank_in,
  input  logic [DATA_WIDTH_ACCUM-1:0] pe_psum_in,
  input  logic                        pe_psum_valid_in,
  output logic                        pe_valid_out,
  output logic [DATA_WIDTH_IN-1:0]    pe_input_out,
  output logic                        pe_switch_out,
  output logic                        pe_accept_w_out,
  output logic [DATA_WIDTH_IN-1:0]    pe_weight_out,
  output logic [INDEX_WIDTH-1:0]      pe_index_out,
  output logic [BANK_WIDTH-1:0]       pe_bank_out,
  output logic [DATA_WIDTH_ACCUM-1:0] pe_psum_out,
  output logic                        pe_psum_valid_out,
  output logic [BANK_WIDTH-1:0]       pe_active_bank,
  output logic                        pe_sat_flag,
  output logic                        pe_wr_conflict
);

  localparam int unsigned DIN  = DATA_WIDTH_IN;
  localparam int unsigned ACC  = DATA_WIDTH_ACCUM;
  localparam int unsigned PW   = 2 * DATA_WIDTH_IN;
  localparam int unsigned EXTW = ACC + 1 - PW;

  logic [DIN-1:0]       bank [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_loaded;

  logic                  capture_c;
  logic                  conflict_c;
  logic                  write_c;
  logic                  compute_c;
  logic                  switch_c;
  logic [BANK_WIDTH-1:0] next_active_c;
  logic [NUM_BANKS-1:0]  loaded_nxt_c;
  logic [DIN-1:0]        w_eff_c;
  logic signed [PW-1:0]  in_ext_c;
  logic signed [PW-1:0]  w_ext_c;
  logic signed [PW-1:0]  prod_c;
  logic [ACC-1:0]        psum_base_c;
  logic [ACC:0]          sum_c;
  logic                  overflow_c;
  logic                  sat_c;
  logic [ACC-1:0]        result_c;

  // Weight capture, bank-pointer advance and loaded-flag bookkeeping
  always_comb begin
    capture_c     = pe_enabled && pe_accept_w_in && (pe_index_in == INDEX_WIDTH'(ROW_ID));
    conflict_c    = capture_c && (pe_bank_in == pe_active_bank);
    write_c       = capture_c && !conflict_c;
    switch_c      = pe_enabled && pe_switch_in;
    next_active_c = (pe_active_bank == BANK_WIDTH'(NUM_BANKS - 1)) ? '0
                  : pe_active_bank + BANK_WIDTH'(1);
    loaded_nxt_c  = bank_loaded;
    if (switch_c) loaded_nxt_c[pe_active_bank] = 1'b0;
    if (write_c)  loaded_nxt_c[pe_bank_in]     = 1'b1;
  end

  // MAC against the pre-switch active bank; unloaded banks contribute zero
  always_comb begin
    compute_c   = pe_enabled && pe_valid_in;
    w_eff_c     = bank_loaded[pe_active_bank] ? bank[pe_active_bank] : '0;
    in_ext_c    = {{DIN{pe_input_in[DIN-1]}}, pe_input_in};
    w_ext_c     = {{DIN{w_eff_c[DIN-1]}}, w_eff_c};
    prod_c      = in_ext_c * w_ext_c;
    psum_base_c = pe_psum_valid_in ? pe_psum_in : '0;
    sum_c       = {psum_base_c[ACC-1], psum_base_c} + {{EXTW{prod_c[PW-1]}}, prod_c};
    overflow_c  = sum_c[ACC] != sum_c[ACC-1];
    sat_c       = (SATURATE != 0) && overflow_c;
    result_c    = sum_c[ACC-1:0];
    if (sat_c) result_c = sum_c[ACC] ? {1'b1, {(ACC-1){1'b0}}} : {1'b0, {(ACC-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_valid_out      <= 1'b0;
      pe_input_out      <= '0;
      pe_switch_out     <= 1'b0;
      pe_accept_w_out   <= 1'b0;
      pe_weight_out     <= '0;
      pe_index_out      <= '0;
      pe_bank_out       <= '0;
      pe_psum_out       <= '0;
      pe_psum_valid_out <= 1'b0;
      pe_active_bank    <= '0;
      pe_sat_flag       <= 1'b0;
      pe_wr_conflict    <= 1'b0;
      bank_loaded       <= '0;
      for (int i = 0; i < int'(NUM_BANKS); i++) bank[i] <= '0;
    end else begin
      pe_valid_out    <= pe_valid_in;
      pe_input_out    <= pe_input_in;
      pe_switch_out   <= pe_switch_in;
      pe_accept_w_out <= pe_accept_w_in && !capture_c;
      pe_weight_out   <= pe_weight_in;
      pe_index_out    <= pe_index_in;
      pe_bank_out     <= pe_bank_in;
      pe_wr_conflict  <= conflict_c;
      bank_loaded     <= loaded_nxt_c;
      if (write_c)  bank[pe_bank_in] <= pe_weight_in;
      if (switch_c) pe_active_bank   <= next_active_c;
      if (compute_c) begin
        pe_psum_out       <= result_c;
        pe_psum_valid_out <= 1'b1;
        pe_sat_flag       <= sat_c;
      end else begin
        pe_psum_out       <= pe_psum_in;
        pe_psum_valid_out <= pe_psum_valid_in;
        pe_sat_flag       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_multibank.sv
// Directed bench for pe_multibank: a saturating and a wrapping instance share stimulus.
module tb_pe_multibank;

  logic        clk = 1'b0;
  logic        rst;
  logic        pe_enabled, pe_valid_in, pe_switch_in, pe_accept_w_in, pe_psum_valid_in;
  logic [7:0]  pe_input_in, pe_weight_in;
  logic [3:0]  pe_index_in;
  logic [1:0]  pe_bank_in;
  logic [31:0] pe_psum_in;

  logic        valid_out, switch_out, accept_w_out, psum_valid_out, sat_flag, wr_conflict;
  logic [7:0]  input_out, weight_out;
  logic [3:0]  index_out;
  logic [1:0]  bank_out, active_bank;
  logic [31:0] psum_out;

  logic        w_valid_out, w_switch_out, w_accept_w_out, w_psum_valid_out, w_sat_flag, w_wr_conflict;
  logic [7:0]  w_input_out, w_weight_out;
  logic [3:0]  w_index_out;
  logic [1:0]  w_bank_out, w_active_bank;
  logic [31:0] w_psum_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_multibank #(.SATURATE(1)) dut (
    .clk(clk), .rst(rst), .pe_enabled(pe_enabled), .pe_valid_in(pe_valid_in),
    .pe_input_in(pe_input_in), .pe_switch_in(pe_switch_in), .pe_accept_w_in(pe_accept_w_in),
    .pe_weight_in(pe_weight_in), .pe_index_in(pe_index_in), .pe_bank_in(pe_bank_in),
    .pe_psum_in(pe_psum_in), .pe_psum_valid_in(pe_psum_valid_in),
    .pe_valid_out(valid_out), .pe_input_out(input_out), .pe_switch_out(switch_out),
    .pe_accept_w_out(accept_w_out), .pe_weight_out(weight_out), .pe_index_out(index_out),
    .pe_bank_out(bank_out), .pe_psum_out(psum_out), .pe_psum_valid_out(psum_valid_out),
    .pe_active_bank(active_bank), .pe_sat_flag(sat_flag), .pe_wr_conflict(wr_conflict)
  );

  pe_multibank #(.SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .pe_enabled(pe_enabled), .pe_valid_in(pe_valid_in),
    .pe_input_in(pe_input_in), .pe_switch_in(pe_switch_in), .pe_accept_w_in(pe_accept_w_in),
    .pe_weight_in(pe_weight_in), .pe_index_in(pe_index_in), .pe_bank_in(pe_bank_in),
    .pe_psum_in(pe_psum_in), .pe_psum_valid_in(pe_psum_valid_in),
    .pe_valid_out(w_valid_out), .pe_input_out(w_input_out), .pe_switch_out(w_switch_out),
    .pe_accept_w_out(w_accept_w_out), .pe_weight_out(w_weight_out), .pe_index_out(w_index_out),
    .pe_bank_out(w_bank_out), .pe_psum_out(w_psum_out), .pe_psum_valid_out(w_psum_valid_out),
    .pe_active_bank(w_active_bank), .pe_sat_flag(w_sat_flag), .pe_wr_conflict(w_wr_conflict)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pe_valid_in = 0; pe_input_in = 0; pe_switch_in = 0; pe_accept_w_in = 0;
    pe_weight_in = 0; pe_index_in = 0; pe_bank_in = 0; pe_psum_in = 0; pe_psum_valid_in = 0;
  endtask

  task automatic load(input logic [1:0] b, input logic [7:0] w);
    pe_accept_w_in = 1; pe_index_in = 4'd0; pe_bank_in = b; pe_weight_in = w;
  endtask

  initial begin
    rst = 1'b0; pe_enabled = 1'b0; idle();
    step(); step();
    chk("rst_psum", psum_out, 32'd0);
    chk("rst_psum_valid", {31'd0, psum_valid_out}, 32'd0);
    chk("rst_active", {30'd0, active_bank}, 32'd0);
    chk("rst_accept_w", {31'd0, accept_w_out}, 32'd0);
    rst = 1'b1;

    // Disabled: pure passthrough, tokens forwarded, switch ignored internally
    pe_psum_in = 32'd1234; pe_psum_valid_in = 1; pe_switch_in = 1;
    load(2'd1, 8'h33);
    step();
    chk("dis_psum0", psum_out, 32'd1234);
    chk("dis_psum_valid", {31'd0, psum_valid_out}, 32'd1);
    chk("dis_accept_w", {31'd0, accept_w_out}, 32'd1);
    chk("dis_weight_fwd", {24'd0, weight_out}, 32'h33);
    chk("dis_switch_fwd", {31'd0, switch_out}, 32'd1);
    chk("dis_active", {30'd0, active_bank}, 32'd0);
    idle(); pe_psum_in = 32'd5678; pe_psum_valid_in = 1;
    step();
    chk("dis_psum1", psum_out, 32'd5678);

    // Load bank1 while computing on unloaded bank0
    pe_enabled = 1'b1; idle();
    load(2'd1, 8'd10); pe_valid_in = 1; pe_input_in = 8'd7; pe_psum_in = 32'd100; pe_psum_valid_in = 1;
    step();
    chk("load_consumed", {31'd0, accept_w_out}, 32'd0);
    chk("unloaded_bank0", psum_out, 32'd100);
    idle(); pe_switch_in = 1;
    step();
    chk("switch_active1", {30'd0, active_bank}, 32'd1);
    idle(); pe_valid_in = 1; pe_input_in = 8'd5; pe_psum_in = 32'd100; pe_psum_valid_in = 1;
    step();
    chk("mac_150", psum_out, 32'd150);
    chk("mac_valid", {31'd0, psum_valid_out}, 32'd1);
    idle(); pe_accept_w_in = 1; pe_index_in = 4'd1; pe_weight_in = 8'hAA; pe_bank_in = 2'd2;
    step();
    chk("nomatch_accept", {31'd0, accept_w_out}, 32'd1);
    chk("nomatch_weight", {24'd0, weight_out}, 32'hAA);
    chk("nomatch_index", {28'd0, index_out}, 32'd1);

    // Switch and compute in the same cycle use the old bank
    idle(); load(2'd2, 8'd20);
    step();
    idle(); pe_valid_in = 1; pe_input_in = 8'd2; pe_switch_in = 1;
    step();
    chk("sw_old_bank", psum_out, 32'd20);
    chk("sw_active2", {30'd0, active_bank}, 32'd2);
    idle(); pe_valid_in = 1; pe_input_in = 8'd3;
    step();
    chk("new_bank_60", psum_out, 32'd60);

    // Load to active bank is dropped
    idle(); load(2'd2, 8'd99);
    step();
    chk("conflict_pulse", {31'd0, wr_conflict}, 32'd1);
    idle(); pe_valid_in = 1; pe_input_in = 8'd1;
    step();
    chk("conflict_kept", psum_out, 32'd20);
    chk("conflict_clear", {31'd0, wr_conflict}, 32'd0);

    // Load to incoming bank during switch, negative weight
    idle(); load(2'd3, 8'hFC); pe_switch_in = 1; pe_valid_in = 1; pe_input_in = 8'd1;
    step();
    chk("sw_load_old", psum_out, 32'd20);
    chk("sw_load_active3", {30'd0, active_bank}, 32'd3);
    chk("sw_load_no_conflict", {31'd0, wr_conflict}, 32'd0);
    idle(); pe_valid_in = 1; pe_input_in = 8'd6;
    step();
    chk("neg_product", psum_out, 32'hFFFF_FFE8);

    // Four switches return to bank3, whose loaded flag was cleared on leaving
    idle(); pe_switch_in = 1;
    for (int i = 0; i < 4; i++) step();
    chk("wrap_active3", {30'd0, active_bank}, 32'd3);
    idle(); pe_valid_in = 1; pe_input_in = 8'd6; pe_psum_in = 32'd7; pe_psum_valid_in = 1;
    step();
    chk("stale_zero", psum_out, 32'd7);

    // Saturation (and wrap on the SATURATE=0 instance)
    idle(); load(2'd0, 8'd127); pe_switch_in = 1;
    step();
    chk("sat_active0", {30'd0, active_bank}, 32'd0);
    idle(); pe_valid_in = 1; pe_input_in = 8'd127; pe_psum_in = 32'h7FFF_FFF0; pe_psum_valid_in = 1;
    step();
    chk("sat_pos", psum_out, 32'h7FFF_FFFF);
    chk("sat_pos_flag", {31'd0, sat_flag}, 32'd1);
    chk("wrap_pos", w_psum_out, 32'h8000_3EF1);
    chk("wrap_pos_flag", {31'd0, w_sat_flag}, 32'd0);
    idle(); pe_valid_in = 1; pe_input_in = 8'h80; pe_psum_in = 32'h8000_0000; pe_psum_valid_in = 1;
    step();
    chk("sat_neg", psum_out, 32'h8000_0000);
    chk("sat_neg_flag", {31'd0, sat_flag}, 32'd1);
    chk("wrap_neg", w_psum_out, 32'h7FFF_C080);
    idle();
    step();
    chk("sat_flag_pulse", {31'd0, sat_flag}, 32'd0);

    // Asynchronous reset mid-load and mid-compute
    idle(); pe_valid_in = 1; pe_input_in = 8'd5; pe_psum_in = 32'd9; pe_psum_valid_in = 1;
    step();
    chk("pre_reset_mac", psum_out, 32'd644);
    load(2'd1, 8'd55);
    #3; rst = 1'b0; #1;
    chk("arst_psum", psum_out, 32'd0);
    chk("arst_valid", {31'd0, valid_out}, 32'd0);
    chk("arst_input", {24'd0, input_out}, 32'd0);
    step();
    idle(); rst = 1'b1;
    pe_switch_in = 1;
    step();
    chk("post_rst_active1", {30'd0, active_bank}, 32'd1);
    idle(); pe_valid_in = 1; pe_input_in = 8'd5; pe_psum_in = 32'd321; pe_psum_valid_in = 1;
    step();
    chk("post_rst_unloaded", psum_out, 32'd321);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
